// File: rtl/fm_path_ctrl_if.sv
// fm_path_ctrl_if: mode-request handshake and coefficient ROM/FIR write bus
interface fm_path_ctrl_if #(
    parameter int TAPS   = 32,
    parameter int COEF_W = 16
);
    localparam int TW = $clog2(TAPS);
    logic              mode_req;
    logic [1:0]        mode_sel;
    logic              mode_ack;
    logic              busy;
    logic [1:0]        cur_mode;
    logic [TW+1:0]     coef_rd_addr;
    logic [COEF_W-1:0] coef_rd_data;
    logic              coef_wr_en;
    logic [TW-1:0]     coef_wr_addr;
    logic [COEF_W-1:0] coef_wr_data;
    modport master (
        output mode_req, mode_sel, coef_rd_data,
        input  mode_ack, busy, cur_mode, coef_rd_addr, coef_wr_en, coef_wr_addr, coef_wr_data
    );
    modport slave (
        input  mode_req, mode_sel, coef_rd_data,
        output mode_ack, busy, cur_mode, coef_rd_addr, coef_wr_en, coef_wr_addr, coef_wr_data
    );
endinterface

// File: rtl/fm_path_ctrl.sv
// fm_path_ctrl: FM datapath mode sequencer (mute, FIR coefficient reload, flush) with ADC over-range monitor
module fm_path_ctrl #(
    parameter int TAPS      = 32,
    parameter int COEF_W    = 16,
    parameter int MUTE_CYC  = 16,
    parameter int OTR_LIMIT = 8
) (
    input  logic          clk_30m,
    input  logic          rst_n,
    fm_path_ctrl_if.slave ctrl_if,
    output logic [1:0]    da_sel_o,
    output logic          da_mute_o,
    input  logic          ad_otr_i,
    input  logic          otr_clr_i,
    output logic          otr_flag_o
);
    localparam int TW = $clog2(TAPS);
    localparam int CW = $clog2(TAPS + MUTE_CYC + 2);
    localparam int OW = $clog2(OTR_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, MUTE, LOAD, FLUSH} state_e;

    state_e            state_q;
    logic [1:0]        new_mode_q, cur_mode_q, da_sel_q;
    logic              ack_q, busy_q, mute_q, wr_en_q;
    logic [CW-1:0]     cnt_q;
    logic [TW+1:0]     rd_addr_q;
    logic [TW-1:0]     wr_addr_q;
    logic [COEF_W-1:0] wr_data_q;
    logic [OW-1:0]     otr_cnt_q, otr_cnt_d;
    logic              otr_flag_q, otr_flag_d;

    // Mode sequencer: a write lags its ROM address by one cycle, so LOAD spans TAPS+1 cycles
    always_ff @(posedge clk_30m or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            new_mode_q <= '0;
            cur_mode_q <= '0;
            da_sel_q   <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            mute_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            ack_q   <= 1'b0;
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE: if (ctrl_if.mode_req) begin
                    ack_q <= 1'b1;
                    if (ctrl_if.mode_sel != cur_mode_q) begin
                        new_mode_q <= ctrl_if.mode_sel;
                        busy_q     <= 1'b1;
                        mute_q     <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= MUTE;
                    end
                end
                MUTE: if (cnt_q == CW'(MUTE_CYC - 1)) begin
                    cnt_q    <= '0;
                    da_sel_q <= new_mode_q;
                    if (new_mode_q[1]) begin
                        rd_addr_q <= {new_mode_q, {TW{1'b0}}};
                        state_q   <= LOAD;
                    end else begin
                        cur_mode_q <= new_mode_q;
                        busy_q     <= 1'b0;
                        mute_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                LOAD: begin
                    if (cnt_q < CW'(TAPS)) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= TW'(cnt_q);
                        wr_data_q <= ctrl_if.coef_rd_data;
                    end
                    if (cnt_q < CW'(TAPS - 1))
                        rd_addr_q <= {new_mode_q, TW'(cnt_q + 1'b1)};
                    if (cnt_q == CW'(TAPS)) begin
                        cnt_q   <= '0;
                        state_q <= FLUSH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FLUSH: if (cnt_q == CW'(TAPS - 1)) begin
                    cur_mode_q <= new_mode_q;
                    busy_q     <= 1'b0;
                    mute_q     <= 1'b0;
                    state_q    <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Over-range run length saturates; the flag sets on the sample that reaches the limit and set beats clear
    always_comb begin
        otr_cnt_d  = !ad_otr_i ? '0 : (otr_cnt_q == OW'(OTR_LIMIT)) ? otr_cnt_q : otr_cnt_q + 1'b1;
        otr_flag_d = (ad_otr_i && otr_cnt_q >= OW'(OTR_LIMIT - 1)) || (otr_flag_q && !otr_clr_i);
    end

    // Over-range state registers, independent of the mode sequencer
    always_ff @(posedge clk_30m or negedge rst_n) begin
        if (!rst_n) begin
            otr_cnt_q  <= '0;
            otr_flag_q <= 1'b0;
        end else begin
            otr_cnt_q  <= otr_cnt_d;
            otr_flag_q <= otr_flag_d;
        end
    end

    assign ctrl_if.mode_ack     = ack_q;
    assign ctrl_if.busy         = busy_q;
    assign ctrl_if.cur_mode     = cur_mode_q;
    assign ctrl_if.coef_rd_addr = rd_addr_q;
    assign ctrl_if.coef_wr_en   = wr_en_q;
    assign ctrl_if.coef_wr_addr = wr_addr_q;
    assign ctrl_if.coef_wr_data = wr_data_q;
    assign da_sel_o             = da_sel_q;
    assign da_mute_o            = mute_q;
    assign otr_flag_o           = otr_flag_q;
endmodule
